// File: rtl/lfsr_pkg.sv
// Shared definitions for the PRBS19 generator/checker pair:
// register width, feedback taps and the checker state encoding.
package lfsr_pkg;

  localparam int LFSR_W = 19;

  // x^19 + x^18 + x^17 + x^14 + 1 -> state bits 18, 17, 16, 13
  localparam logic [LFSR_W-1:0] TAP_MASK = 19'h7_2000;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

endpackage

// File: rtl/lfsr_next.sv
// One step of the PRBS19 recurrence: predicted next bit and the state after
// shifting that bit in. Used by both the generator and the checker.
module lfsr_next
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] s_i,
  output logic              p_o,
  output logic [LFSR_W-1:0] s_next_o
);

  always_comb begin
    p_o      = ^(s_i & TAP_MASK);
    s_next_o = {s_i[LFSR_W-2:0], p_o};
  end

endmodule

// File: rtl/lfsr_checker.sv
// PRBS19 receive checker: self-synchronises to the incoming stream, then
// flags and counts bit errors and drops lock on excessive error density.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT  = 32,
  parameter int WINDOW    = 64,
  parameter int LOSS_ERRS = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic             bit_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] bit_cnt_o
);

  localparam int SEED_W  = $clog2(LFSR_W);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WBIT_W  = $clog2(WINDOW);
  localparam int WERR_W  = $clog2(LOSS_ERRS + 1);

  chk_state_e          state_q, state_d;
  logic [LFSR_W-1:0]   s_q, s_d;
  logic [SEED_W-1:0]   seed_cnt_q, seed_cnt_d;
  logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
  logic [WBIT_W-1:0]   win_bit_q, win_bit_d;
  logic [WERR_W-1:0]   win_err_q, win_err_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;

  logic                p;
  logic [LFSR_W-1:0]   s_pred;
  logic [LFSR_W-1:0]   s_rx;
  logic                mismatch;
  logic                err_ev;
  logic                bit_ev;
  logic [WERR_W-1:0]   win_err_inc;

  lfsr_next u_next (
    .s_i      (s_q),
    .p_o      (p),
    .s_next_o (s_pred)
  );

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    win_bit_d   = win_bit_q;
    win_err_d   = win_err_q;
    err_ev      = 1'b0;
    bit_ev      = 1'b0;
    s_rx        = {s_q[LFSR_W-2:0], bit_i};
    mismatch    = (bit_i != p);
    win_err_inc = win_err_q + WERR_W'(mismatch);

    if (valid_i) begin
      unique case (state_q)
        SEED: begin
          s_d = s_rx;
          if (seed_cnt_q == SEED_W'(LFSR_W - 1)) begin
            state_d     = VERIFY;
            seed_cnt_d  = '0;
            match_cnt_d = '0;
          end else begin
            seed_cnt_d = seed_cnt_q + SEED_W'(1);
          end
        end
        VERIFY: begin
          s_d = s_rx;
          // An all-zero register is a fixed point of the recurrence and
          // would "match" a dead line forever, so it never counts.
          if (!mismatch && (s_q != '0) && (s_rx != '0)) begin
            if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_d     = LOCKED;
              match_cnt_d = '0;
              win_bit_d   = '0;
              win_err_d   = '0;
            end else begin
              match_cnt_d = match_cnt_q + MATCH_W'(1);
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so one bad bit yields one error.
          s_d       = s_pred;
          bit_ev    = 1'b1;
          err_ev    = mismatch;
          win_err_d = win_err_inc;
          if (win_err_inc == WERR_W'(LOSS_ERRS)) begin
            state_d    = SEED;
            seed_cnt_d = '0;
          end
          if (win_bit_q == WBIT_W'(WINDOW - 1)) begin
            win_bit_d = '0;
            win_err_d = '0;
          end else begin
            win_bit_d = win_bit_q + WBIT_W'(1);
          end
        end
        default: state_d = SEED;
      endcase
    end

    err_d = err_ev;

    if (clr_i)                              err_cnt_d = CNT_W'(err_ev);
    else if (err_ev && (err_cnt_q != '1))   err_cnt_d = err_cnt_q + CNT_W'(1);
    else                                    err_cnt_d = err_cnt_q;

    if (clr_i)                              bit_cnt_d = CNT_W'(bit_ev);
    else if (bit_ev && (bit_cnt_q != '1))   bit_cnt_d = bit_cnt_q + CNT_W'(1);
    else                                    bit_cnt_d = bit_cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SEED;
      s_q         <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_bit_q   <= '0;
      win_err_q   <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_bit_q   <= win_bit_d;
      win_err_q   <= win_err_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign locked_o  = (state_q == LOCKED);
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;
  assign bit_cnt_o = bit_cnt_q;

endmodule
